// File: rtl/lynxTypes.sv
// lynxTypes: shared types and constants for the stream RLE encoder.
// Holds the FSM state enum, header field layout and default run limit.
package lynxTypes;

    localparam int AXI_DATA_BITS = 512;
    localparam int AXI_ID_BITS   = 6;

    localparam int RLE_LEN_LSB  = 0;
    localparam int RLE_LEN_BITS = 32;

    localparam int unsigned RUN_MAX_DEFAULT = 32'd65535;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACCUM     = 2'd1,
        ST_EMIT_HDR  = 2'd2,
        ST_EMIT_DATA = 2'd3
    } rle_state_e;

endpackage

// File: rtl/AXI4SR.sv
// AXI4SR: AXI4-Stream bundle with tid, used between streaming stages.
// Modport s is the consumer side, modport m the producer side.
interface AXI4SR #(
    parameter int DATA_BITS = lynxTypes::AXI_DATA_BITS
) ();

    logic [DATA_BITS-1:0]             tdata;
    logic [DATA_BITS/8-1:0]           tkeep;
    logic [lynxTypes::AXI_ID_BITS-1:0] tid;
    logic                             tlast;
    logic                             tvalid;
    logic                             tready;

    modport s (
        input  tdata,
        input  tkeep,
        input  tid,
        input  tlast,
        input  tvalid,
        output tready
    );

    modport m (
        output tdata,
        output tkeep,
        output tid,
        output tlast,
        output tvalid,
        input  tready
    );

endinterface

// File: rtl/rle_out_reg.sv
// rle_out_reg: single-entry registered AXI4SR output slice with a load strobe.
// Payload only changes on load, so it holds steady while stalled.
module rle_out_reg
    import lynxTypes::*;
#(
    parameter int DATA_BITS = AXI_DATA_BITS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [DATA_BITS-1:0]   ld_data,
    input  logic [DATA_BITS/8-1:0] ld_keep,
    input  logic [AXI_ID_BITS-1:0] ld_id,
    input  logic                   ld_last,
    AXI4SR.m                       axis_out
);

    localparam int KEEP_BITS = DATA_BITS / 8;

    logic                   valid_q, valid_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic [KEEP_BITS-1:0]   keep_q, keep_d;
    logic [AXI_ID_BITS-1:0] id_q, id_d;
    logic                   last_q, last_d;

    // Next slice contents: drop on handshake, overwrite on load.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        id_d    = id_q;
        last_d  = last_q;
        if (valid_q && axis_out.tready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            data_d  = ld_data;
            keep_d  = ld_keep;
            id_d    = ld_id;
            last_d  = ld_last;
        end
    end

    // Slice registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            id_q    <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    assign axis_out.tvalid = valid_q;
    assign axis_out.tdata  = data_q;
    assign axis_out.tkeep  = keep_q;
    assign axis_out.tid    = id_q;
    assign axis_out.tlast  = last_q;

endmodule

// File: rtl/stream_rle_encoder.sv
// stream_rle_encoder: collapses repeated AXI4SR beats into header+data runs.
// Define RLE_STATS_EN to add the stat_in_beats/stat_out_beats/stat_runs ports.
module stream_rle_encoder
    import lynxTypes::*;
#(
    parameter int          DATA_BITS = AXI_DATA_BITS,
    parameter int unsigned RUN_MAX   = RUN_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    AXI4SR.s            axis_in,
`ifdef RLE_STATS_EN
    output logic [63:0] stat_in_beats,
    output logic [63:0] stat_out_beats,
    output logic [31:0] stat_runs,
`endif
    AXI4SR.m            axis_out
);

    localparam int KEEP_BITS = DATA_BITS / 8;

    rle_state_e state_q, state_d;

    logic [RLE_LEN_BITS-1:0] count_q, count_d;
    logic                    in_rdy_q, in_rdy_d;

    logic [DATA_BITS-1:0]    held_data_q, held_data_d;
    logic [KEEP_BITS-1:0]    held_keep_q, held_keep_d;
    logic [AXI_ID_BITS-1:0]  held_id_q, held_id_d;
    logic                    held_last_q, held_last_d;

    logic                    pend_v_q, pend_v_d;
    logic [DATA_BITS-1:0]    pend_data_q, pend_data_d;
    logic [KEEP_BITS-1:0]    pend_keep_q, pend_keep_d;
    logic [AXI_ID_BITS-1:0]  pend_id_q, pend_id_d;
    logic                    pend_last_q, pend_last_d;

    logic                    in_hs;
    logic                    out_hs;
    logic                    held_open;
    logic                    run_full;
    logic                    in_match;
    logic                    extend;
    logic                    close_now;

    logic                    out_load;
    logic [DATA_BITS-1:0]    out_data;
    logic [KEEP_BITS-1:0]    out_keep;
    logic [AXI_ID_BITS-1:0]  out_id;
    logic                    out_last;
    logic [DATA_BITS-1:0]    hdr_data;

    assign in_hs  = axis_in.tvalid && in_rdy_q;
    assign out_hs = axis_out.tvalid && axis_out.tready;

    assign held_open = (held_keep_q == {KEEP_BITS{1'b1}}) && !held_last_q;
    assign run_full  = (count_q == RLE_LEN_BITS'(RUN_MAX));
    assign in_match  = held_open && !run_full
                    && (axis_in.tdata == held_data_q)
                    && (axis_in.tkeep == held_keep_q)
                    && (axis_in.tid == held_id_q);
    assign extend    = in_hs && in_match;
    assign close_now = !held_open || run_full;

    assign axis_in.tready = in_rdy_q;

    // State, run counter, held/pending beats and input ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            in_rdy_q    <= 1'b0;
            held_data_q <= '0;
            held_keep_q <= '0;
            held_id_q   <= '0;
            held_last_q <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_data_q <= '0;
            pend_keep_q <= '0;
            pend_id_q   <= '0;
            pend_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            in_rdy_q    <= in_rdy_d;
            held_data_q <= held_data_d;
            held_keep_q <= held_keep_d;
            held_id_q   <= held_id_d;
            held_last_q <= held_last_d;
            pend_v_q    <= pend_v_d;
            pend_data_q <= pend_data_d;
            pend_keep_q <= pend_keep_d;
            pend_id_q   <= pend_id_d;
            pend_last_q <= pend_last_d;
        end
    end

    // Next state: a run closes on mismatch, full count, tlast or partial keep.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_hs) state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (close_now || (in_hs && !extend)) state_d = ST_EMIT_HDR;
            end
            ST_EMIT_HDR: begin
                if (out_hs) state_d = ST_EMIT_DATA;
            end
            ST_EMIT_DATA: begin
                if (out_hs) state_d = pend_v_q ? ST_ACCUM : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Header beat: run length in the low field, everything else zero.
    always_comb begin
        hdr_data = '0;
        hdr_data[RLE_LEN_LSB +: RLE_LEN_BITS] = count_q;
    end

    // Outputs: input ready follows the next state; output slice loads.
    always_comb begin
        in_rdy_d = (state_d == ST_IDLE) || (state_d == ST_ACCUM);
        out_load = 1'b0;
        out_data = hdr_data;
        out_keep = {KEEP_BITS{1'b1}};
        out_id   = held_id_q;
        out_last = 1'b0;
        unique case (state_q)
            ST_ACCUM: begin
                out_load = (state_d == ST_EMIT_HDR);
            end
            ST_EMIT_HDR: begin
                if (out_hs) begin
                    out_load = 1'b1;
                    out_data = held_data_q;
                    out_keep = held_keep_q;
                    out_last = held_last_q;
                end
            end
            default: ;
        endcase
    end

    // Run datapath: capture, extend, park a mismatching beat, reload it.
    always_comb begin
        count_d     = count_q;
        held_data_d = held_data_q;
        held_keep_d = held_keep_q;
        held_id_d   = held_id_q;
        held_last_d = held_last_q;
        pend_v_d    = pend_v_q;
        pend_data_d = pend_data_q;
        pend_keep_d = pend_keep_q;
        pend_id_d   = pend_id_q;
        pend_last_d = pend_last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_hs) begin
                    held_data_d = axis_in.tdata;
                    held_keep_d = axis_in.tkeep;
                    held_id_d   = axis_in.tid;
                    held_last_d = axis_in.tlast;
                    count_d     = 32'd1;
                end
            end
            ST_ACCUM: begin
                if (extend) begin
                    count_d     = count_q + 32'd1;
                    held_last_d = axis_in.tlast;
                end else if (in_hs) begin
                    pend_v_d    = 1'b1;
                    pend_data_d = axis_in.tdata;
                    pend_keep_d = axis_in.tkeep;
                    pend_id_d   = axis_in.tid;
                    pend_last_d = axis_in.tlast;
                end
            end
            ST_EMIT_DATA: begin
                if (out_hs) begin
                    if (pend_v_q) begin
                        held_data_d = pend_data_q;
                        held_keep_d = pend_keep_q;
                        held_id_d   = pend_id_q;
                        held_last_d = pend_last_q;
                        count_d     = 32'd1;
                        pend_v_d    = 1'b0;
                    end else begin
                        count_d = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    rle_out_reg #(
        .DATA_BITS (DATA_BITS)
    ) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (out_load),
        .ld_data  (out_data),
        .ld_keep  (out_keep),
        .ld_id    (out_id),
        .ld_last  (out_last),
        .axis_out (axis_out)
    );

`ifdef RLE_STATS_EN
    logic [63:0] st_in_q, st_in_d;
    logic [63:0] st_out_q, st_out_d;
    logic [31:0] st_runs_q, st_runs_d;
    logic        run_done;

    assign run_done = (state_q == ST_EMIT_DATA) && out_hs;

    // Free-running statistics, wrapping at their width.
    always_comb begin
        st_in_d   = st_in_q + {63'd0, in_hs};
        st_out_d  = st_out_q + {63'd0, out_hs};
        st_runs_d = st_runs_q + {31'd0, run_done};
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_in_q   <= '0;
            st_out_q  <= '0;
            st_runs_q <= '0;
        end else begin
            st_in_q   <= st_in_d;
            st_out_q  <= st_out_d;
            st_runs_q <= st_runs_d;
        end
    end

    assign stat_in_beats  = st_in_q;
    assign stat_out_beats = st_out_q;
    assign stat_runs      = st_runs_q;
`endif

endmodule
